// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
// Used with the ADDSUB_FLAGS_EN build option of addsub_seq_ctrl.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIBBLE_W = 4;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_ctrl_cla4.sv
// 4-bit carry-look-ahead add/sub slice, purely combinational.
// m_i=1 inverts B so that with cin_i=1 the slice subtracts.
import alu_pkg::*;

module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       m_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o,
  output logic       c3_o
);

  logic [3:0] bx;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    bx = b_i ^ {4{m_i}};
    g  = a_i & bx;
    p  = a_i ^ bx;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_o    = p ^ c[3:0];
    cout_o = c[4];
    c3_o   = c[3];
  end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/sub sequenced one nibble per cycle, LSB first.
// Define ADDSUB_FLAGS_EN to add the rsp_ovf / rsp_zero flag outputs.
import alu_pkg::*;

module addsub_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             busy
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             rsp_ovf,
  output logic             rsp_zero
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NIBBLES - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             sub_q, carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             s_cout, s_c3, last;

`ifdef ADDSUB_FLAGS_EN
  logic ovf_q, zero_q;
`else
  logic unused_c3;
  assign unused_c3 = s_c3;
`endif

  cla4_slice u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .m_i    (sub_q),
    .cin_i  (carry_q),
    .s_o    (s_nib),
    .cout_o (s_cout),
    .c3_o   (s_c3)
  );

  always_comb begin
    a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    res_d = res_q;
    res_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_nib;
    last  = (idx_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef ADDSUB_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        a_q     <= req_a;
        b_q     <= req_b;
        sub_q   <= req_sub;
        carry_q <= req_sub;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        res_q   <= res_d;
        carry_q <= s_cout;
        idx_q   <= idx_q + 1'b1;
`ifdef ADDSUB_FLAGS_EN
        if (last) begin
          ovf_q  <= s_c3 ^ s_cout;
          zero_q <= (res_d == '0);
        end
`endif
      end
    end
  end

  // carry_q holds the final carry until the next accept
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_result = res_q;
  assign rsp_cout   = carry_q;
`ifdef ADDSUB_FLAGS_EN
  assign rsp_ovf    = ovf_q;
  assign rsp_zero   = zero_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl at WIDTH=16.
// Flag checks are active only when ADDSUB_FLAGS_EN is defined.
module tb_addsub_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a, req_b;
  logic        req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_cout;
  logic        busy;
`ifdef ADDSUB_FLAGS_EN
  logic        rsp_ovf, rsp_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  addsub_seq_ctrl #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
`ifdef ADDSUB_FLAGS_EN
    ,
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  // Accepts one request, returns latency to rsp_valid and captured outputs.
  task automatic run_op(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output int          lat,
    output logic [15:0] res,
    output logic        cout,
    output logic        ovf,
    output logic        zero
  );
    req_a = a;
    req_b = b;
    req_sub = sub;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = 16'hDEAD;
    req_b = 16'hBEEF;
    req_sub = ~sub;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) lat = 99;
    res  = rsp_result;
    cout = rsp_cout;
`ifdef ADDSUB_FLAGS_EN
    ovf  = rsp_ovf;
    zero = rsp_zero;
`else
    ovf  = 1'b0;
    zero = 1'b0;
`endif
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    req_sub = ALU_OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 001",
               {rsp_valid, busy, req_ready});
    end
    n_cmp++;
    if ({rsp_result, rsp_cout} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0",
               {rsp_result, rsp_cout});
    end
  endtask

  task automatic test_add_basic();
    int lat;
    logic [15:0] r;
    logic c, v, z;
    run_op(16'h1234, 16'h0FFF, ALU_OP_ADD,
           lat, r, c, v, z);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL add_latency got %0d want 4", lat);
    end
    n_cmp++;
    if ({r, c} !== {16'h2233, 1'b0}) begin
      n_bad++;
      $display("FAIL add_basic got %h/%b want 2233/0",
               r, c);
    end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++;
    if ({v, z} !== 2'b00) begin
      n_bad++;
      $display("FAIL add_basic_flags got %b want 00",
               {v, z});
    end
`endif
    finish_rsp();
  endtask

  task automatic test_add_wrap();
    int lat;
    logic [15:0] r;
    logic c, v, z;
    run_op(16'hFFFF, 16'h0001, ALU_OP_ADD,
           lat, r, c, v, z);
    n_cmp++;
    if ({r, c} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL add_wrap got %h/%b want 0000/1",
               r, c);
    end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++;
    if ({v, z} !== 2'b01) begin
      n_bad++;
      $display("FAIL add_wrap_flags got %b want 01",
               {v, z});
    end
`endif
    finish_rsp();
  endtask

  task automatic test_sub_borrow_ovf();
    int lat;
    logic [15:0] r;
    logic c, v, z;
    run_op(16'h0005, 16'h0007, ALU_OP_SUB,
           lat, r, c, v, z);
    n_cmp++;
    if ({r, c} !== {16'hFFFE, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_borrow got %h/%b want FFFE/0",
               r, c);
    end
    finish_rsp();
    run_op(16'h7FFF, 16'h0001, ALU_OP_ADD,
           lat, r, c, v, z);
    n_cmp++;
    if ({r, c} !== {16'h8000, 1'b0}) begin
      n_bad++;
      $display("FAIL add_ovf got %h/%b want 8000/0",
               r, c);
    end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++;
    if ({v, z} !== 2'b10) begin
      n_bad++;
      $display("FAIL add_ovf_flags got %b want 10",
               {v, z});
    end
`endif
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] r;
    logic c, v, z;
    int held_bad;
    run_op(16'h00AA, 16'h0011, ALU_OP_ADD,
           lat, r, c, v, z);
    req_a = 16'h0100;
    req_b = 16'h0200;
    req_sub = ALU_OP_ADD;
    req_valid = 1'b1;
    held_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if ({rsp_valid, req_ready} !== 2'b10 ||
          rsp_result !== 16'h00BB)
        held_bad++;
    end
    n_cmp++;
    if (held_bad !== 0) begin
      n_bad++;
      $display("FAIL hold_done got %0d bad cycles want 0",
               held_bad);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL idle_after_hs got %b want 01",
               {rsp_valid, req_ready});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_cmp++;
    if ({busy, req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL second_accept got %b want 10",
               {busy, req_ready});
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 4 || rsp_result !== 16'h0300) begin
      n_bad++;
      $display("FAIL second_op got %0d/%h want 4/0300",
               lat, rsp_result);
    end
    finish_rsp();
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [15:0] r;
    logic c, v, z;
    req_a = 16'h1111;
    req_b = 16'h2222;
    req_sub = ALU_OP_ADD;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_reset got %b want 001",
               {rsp_valid, busy, req_ready});
    end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_silent got %b want 0",
               rsp_valid);
    end
    run_op(16'h0001, 16'h0001, ALU_OP_ADD,
           lat, r, c, v, z);
    n_cmp++;
    if (lat !== 4 || {r, c} !== {16'h0002, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset got %0d/%h/%b want 4/0002/0",
               lat, r, c);
    end
    finish_rsp();
  endtask

  task automatic test_sub_ovf();
    int lat;
    logic [15:0] r;
    logic c, v, z;
    run_op(16'h8000, 16'h0001, ALU_OP_SUB,
           lat, r, c, v, z);
    n_cmp++;
    if ({r, c} !== {16'h7FFF, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_ovf got %h/%b want 7FFF/1",
               r, c);
    end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++;
    if ({v, z} !== 2'b10) begin
      n_bad++;
      $display("FAIL sub_ovf_flags got %b want 10",
               {v, z});
    end
`endif
    finish_rsp();
    run_op(16'h4321, 16'h4321, ALU_OP_SUB,
           lat, r, c, v, z);
    n_cmp++;
    if ({r, c} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_equal got %h/%b want 0000/1",
               r, c);
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_wrap();
    test_sub_borrow_ovf();
    test_back_to_back();
    test_mid_reset();
    test_sub_ovf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
